blk_pingpong_ctrl: RTL
======================

// Module: blk_pingpong_ctrl
// PURPOSE
//  Ping-pong 8x8 block buffer controller between the pixel stream and the DCT stage.
//  - Write side: accepts a valid/sop/eop sample stream and writes each 64-sample block
//    into one half of a 128-entry simple dual-port RAM (ramWr-style port).
//  - Read side: when a half is full, reads it out in raster or transposed order
//    (ramRd-style port) and emits a dctPort_t-style stream with sop/eop framing.
//  - Owns bank allocation, input back-pressure and framing-error detection.
// PARAMETERS
//  DATA_WIDTH  11  sample width, write and read
//  TRANSPOSE   1   1: column-major read order (addr = {rcnt[2:0],rcnt[5:3]}); 0: raster
// PORTS
//  clk        in   1           single clock; all logic on its rising edge
//  rst        in   1           asynchronous reset, active-high
//  in_data    in   DATA_WIDTH  input sample
//  in_valid   in   1           in_data valid
//  in_sop     in   1           first sample of a block, qualified by in_valid
//  in_eop     in   1           last sample of a block, qualified by in_valid
//  in_ready   out  1           controller can accept a sample this cycle
//  wr_en      out  1           RAM write enable
//  wr_addr    out  7           {bank, 6-bit index}
//  wr_data    out  DATA_WIDTH  RAM write data
//  rd_en      out  1           RAM read enable
//  rd_addr    out  7           {bank, 6-bit index}
//  rd_data    in   DATA_WIDTH  RAM read data; valid 1 cycle after rd_en
//  out_data   out  DATA_WIDTH  output sample (= rd_data)
//  out_valid  out  1           output sample valid
//  out_sop    out  1           first output sample of a block
//  out_eop    out  1           last output sample of a block
//  frm_err    out  1           one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset (async, rst=1): full[1:0]=0, wb=rb=0, wcnt=rcnt=0, FSM=IDLE.
//  - Outputs: all 0 except in_ready=1.
//  - Reset mid-block discards every partially written or partially read block.
//  Accept: a sample is accepted when in_valid & in_ready.
//  - in_ready = ~full[wb], combinational from registers.
//  Write side (accepted sample):
//  - wr_en=1, wr_data=in_data, wr_addr={wb,wcnt} in the same cycle (combinational).
//  - in_sop with wcnt!=0: frm_err pulses next cycle; sample is written at index 0;
//    wcnt restarts at 1.
//  - in_eop with wcnt!=63: frm_err pulses; the block is not closed.
//  - Block close: the accepted sample at wcnt==63 sets full[wb], toggles wb and clears
//    wcnt at that clock edge. Closing happens on count, not on eop.
//  Read FSM, states IDLE / READ:
//  - IDLE: if full[rb], go to READ with rcnt=0.
//  - READ: rd_en=1, rd_addr={rb,order(rcnt)}, rcnt increments every cycle (no stall).
//  - At rcnt==63: clear full[rb], toggle rb. If full[~rb] is set at that cycle, stay in
//    READ with rcnt=0 (back-to-back, no gap); else go to IDLE.
//  Output pipeline:
//  - out_valid, out_sop (rcnt==0) and out_eop (rcnt==63) are rd_en-qualified flags
//    registered by 1 cycle.
//  - out_data = rd_data.
//  Latency: last write in cycle N -> full set at edge N; READ entered at edge N+1;
//  first rd_en in cycle N+2; first out_valid+out_sop in cycle N+3.
//  Simultaneous events:
//  - Block close on bank X and read finish on bank Y in the same cycle: both take effect.
//  - Set and clear of the same bank in one cycle cannot occur: in_ready blocks writes
//    to a full bank.
//  Both banks full: in_ready=0 until the cycle after the read side clears full[wb].
//  Samples are never dropped or overwritten.
// TESTING
//  1. One block, values 0..63, TRANSPOSE=1 -> out 0,8,16..56,1,9..63.
//     sop on 0, eop on 63. First out_valid 3 cycles after the last write.
//  2. Two blocks, in_valid held high -> 128 outputs. Block 1 sop in the cycle directly
//     after block 0 eop.
//  3. Three blocks, in_valid held high -> in_ready drops while both banks are full.
//     Resumes the cycle after bank 0 is freed. All 192 samples out in order, none lost.
//  4. in_sop at wcnt=20 -> frm_err 1-cycle pulse. Partial block never output. Following
//     64 samples output as one correct block.
//  5. rst asserted at rcnt=30 -> all outputs 0 immediately, in_ready=1. Next full block
//     output from sop with correct data.
//  6. TRANSPOSE=0, values 100..163 -> out 100..163 in raster order.

Source files
------------

// File: rtl/blk_pingpong_ctrl_if.sv
// Stream-in, RAM write/read and stream-out signal bundle of the ping-pong block buffer controller.
// The controller takes the slave view; the pixel source, RAM and DCT side take the master view.
interface blk_pingpong_ctrl_if #(
  parameter int DATA_WIDTH = 11
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_ready;
  logic                  wr_en;
  logic [6:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [6:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic                  frm_err;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, rd_data,
    output in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr,
           out_data, out_valid, out_sop, out_eop, frm_err
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, rd_data,
    input  in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr,
           out_data, out_valid, out_sop, out_eop, frm_err
  );
endinterface

// File: rtl/blk_pingpong_ctrl.sv
// Ping-pong 8x8 block buffer controller: fills one 64-entry RAM half from the pixel stream
// while the other half is read out (raster or transposed) towards the DCT stage.
module blk_pingpong_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter bit TRANSPOSE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  blk_pingpong_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  rd_state_t             state_r;
  logic [1:0]            full_r;
  logic                  wb_r;
  logic                  rb_r;
  logic [5:0]            wcnt_r;
  logic [5:0]            rcnt_r;
  logic                  out_valid_r;
  logic                  out_sop_r;
  logic                  out_eop_r;
  logic                  frm_err_r;

  logic                  accept_s;
  logic [5:0]            widx_s;
  logic                  close_s;
  logic                  rd_en_s;
  logic                  rd_last_s;
  logic                  bad_frame_s;
  logic [5:0]            ridx_s;
  logic [1:0]            full_set_s;
  logic [1:0]            full_clr_s;
  logic [DATA_WIDTH-1:0] out_data_s;

  // Write-side acceptance, read-side decode and bank full set/clear requests
  always_comb begin
    accept_s    = bus.in_valid & ~full_r[wb_r];
    // A sop always restarts the block at index 0, even mid-block.
    widx_s      = bus.in_sop ? 6'd0 : wcnt_r;
    close_s     = accept_s & (widx_s == 6'd63);
    rd_en_s     = (state_r == READ);
    rd_last_s   = rd_en_s & (rcnt_r == 6'd63);
    bad_frame_s = accept_s & ((bus.in_sop & (wcnt_r != 6'd0)) |
                              (bus.in_eop & (wcnt_r != 6'd63)));
    ridx_s      = TRANSPOSE ? {rcnt_r[2:0], rcnt_r[5:3]} : rcnt_r;
    full_set_s  = close_s   ? (2'b01 << wb_r) : 2'b00;
    full_clr_s  = rd_last_s ? (2'b01 << rb_r) : 2'b00;
    out_data_s  = out_valid_r ? bus.rd_data : {DATA_WIDTH{1'b0}};
  end

  assign bus.in_ready  = ~full_r[wb_r];
  assign bus.wr_en     = accept_s;
  assign bus.wr_addr   = {wb_r, widx_s};
  assign bus.wr_data   = bus.in_data;
  assign bus.rd_en     = rd_en_s;
  assign bus.rd_addr   = {rb_r, ridx_s};
  assign bus.out_data  = out_data_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sop   = out_sop_r;
  assign bus.out_eop   = out_eop_r;
  assign bus.frm_err   = frm_err_r;

  // Write bank pointer, sample index and framing-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_r      <= 1'b0;
      wcnt_r    <= 6'd0;
      frm_err_r <= 1'b0;
    end else begin
      frm_err_r <= bad_frame_s;
      if (close_s) begin
        wb_r   <= ~wb_r;
        wcnt_r <= 6'd0;
      end else if (accept_s) begin
        wcnt_r <= widx_s + 6'd1;
      end else begin
        wcnt_r <= wcnt_r;
      end
    end
  end

  // Bank full flags; set and clear never target the same bank in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r | full_set_s) & ~full_clr_s;
    end
  end

  // Read FSM and the one-cycle output framing pipeline aligned with rd_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rb_r        <= 1'b0;
      rcnt_r      <= 6'd0;
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else begin
      out_valid_r <= rd_en_s;
      out_sop_r   <= rd_en_s & (rcnt_r == 6'd0);
      out_eop_r   <= rd_last_s;
      case (state_r)
        IDLE: begin
          if (full_r[rb_r]) begin
            state_r <= READ;
            rcnt_r  <= 6'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          // rcnt wraps to 0 after 63, so a back-to-back block starts cleanly.
          rcnt_r <= rcnt_r + 6'd1;
          if (rd_last_s) begin
            rb_r    <= ~rb_r;
            state_r <= full_r[~rb_r] ? READ : IDLE;
          end else begin
            state_r <= READ;
          end
        end
        default: begin
          state_r <= IDLE;
          rcnt_r  <= 6'd0;
        end
      endcase
    end
  end

endmodule
